// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-PC sequencer.
// Holds the FSM state encoding and the redirect-target legality rule.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_TRAP   = 2'd2
   } state_t;

   localparam int DEFAULT_RESET_PC = 0;
   localparam int MAX_FLUSH_CYCLES = 7;

   // A target is illegal if it is not word aligned or does not fit in pc_w bits.
   function automatic logic is_illegal_tgt(input logic [31:0] tgt, input int pc_w);
      logic bad;
      bad = (tgt[1:0] != 2'b00);
      for (int i = 0; i < 32; i++) begin
         if ((i >= pc_w) && tgt[i]) bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target mux: JALR wins over a taken branch; JALR bit 0 is cleared.
// Also flags targets that are misaligned or outside the fetch address range.
module pc_target_sel
   import pc_seq_pkg::*;
#(
   parameter int PC_W = 9
) (
   input  logic            jalr_sel_i,
   input  logic [31:0]     br_pc_i,
   input  logic [31:0]     jalr_target_i,
   output logic [PC_W-1:0] tgt_o,
   output logic            illegal_o
);

   logic [31:0] full_tgt;

   always_comb begin
      full_tgt = br_pc_i;
      if (jalr_sel_i) full_tgt = jalr_target_i & ~32'd1;
   end

   assign tgt_o     = full_tgt[PC_W-1:0];
   assign illegal_o = is_illegal_tgt(full_tgt, PC_W);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: free-runs PC+4, takes EX redirects, inserts refill bubbles
// after each accepted redirect and traps permanently on an illegal target.
//
// state     | meaning
// ST_RUN    | fetching; PC advances, holds on Stall, or takes a redirect
// ST_BUBBLE | instruction memory refilling after a redirect; fetch slot invalid
// ST_TRAP   | illegal redirect target seen; frozen until reset
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              PC_W         = 9,
   parameter logic [PC_W-1:0] RESET_PC     = PC_W'(DEFAULT_RESET_PC),
   parameter int              FLUSH_CYCLES = 2,
   parameter int              CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Stall,
   input  logic             PcSel,
   input  logic [31:0]      BrPC,
   input  logic             JalrSel,
   input  logic [31:0]      JalrTarget,
   output logic [PC_W-1:0]  Cur_PC,
   output logic             PC_Valid,
   output logic             Flush,
   output logic             Misalign,
   output logic [CNT_W-1:0] RedirectCnt
);

   localparam logic [2:0] BUB_INIT = (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;

   state_t           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [2:0]       bub_q;
   logic             misalign_q;
   logic [CNT_W-1:0] redir_cnt_q;

   logic [PC_W-1:0]  tgt;
   logic             tgt_illegal;
   logic             redir;
   logic             in_run;

   pc_target_sel #(
      .PC_W (PC_W)
   ) u_target_sel (
      .jalr_sel_i    (JalrSel),
      .br_pc_i       (BrPC),
      .jalr_target_i (JalrTarget),
      .tgt_o         (tgt),
      .illegal_o     (tgt_illegal)
   );

   assign redir  = JalrSel | PcSel;
   assign in_run = (state_q == ST_RUN) & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_PC;
         bub_q       <= 3'd0;
         misalign_q  <= 1'b0;
         redir_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               // A redirect overrides Stall: the stalled slot is being squashed anyway.
               if (redir) begin
                  if (tgt_illegal) begin
                     state_q    <= ST_TRAP;
                     misalign_q <= 1'b1;
                  end else begin
                     pc_q <= tgt;
                     if (redir_cnt_q != '1) redir_cnt_q <= redir_cnt_q + 1'b1;
                     if (FLUSH_CYCLES > 0) begin
                        state_q <= ST_BUBBLE;
                        bub_q   <= BUB_INIT;
                     end
                  end
               end else if (!Stall) begin
                  pc_q <= pc_q + PC_W'(4);
               end
            end
            ST_BUBBLE: begin
               if (bub_q == 3'd0) state_q <= ST_RUN;
               else               bub_q   <= bub_q - 3'd1;
            end
            ST_TRAP: ;
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign Cur_PC      = pc_q;
   assign PC_Valid    = in_run;
   assign Flush       = in_run & redir;
   assign Misalign    = misalign_q;
   assign RedirectCnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a default build (2 bubbles, 16-bit counter)
// and a zero-bubble build with a 3-bit counter share stimulus against a cycle model.
module tb_pc_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, pcsel, jsel;
   logic [31:0] br, jt;

   logic [8:0]  pc_a, pc_b;
   logic        v_a, f_a, m_a, v_b, f_b, m_b;
   logic [15:0] c_a;
   logic [2:0]  c_b;

   int checks   = 0;
   int failures = 0;

   pc_sequencer #(.PC_W(9), .RESET_PC(9'd0), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst), .Stall(stall), .PcSel(pcsel), .BrPC(br),
      .JalrSel(jsel), .JalrTarget(jt), .Cur_PC(pc_a), .PC_Valid(v_a),
      .Flush(f_a), .Misalign(m_a), .RedirectCnt(c_a)
   );

   pc_sequencer #(.PC_W(9), .RESET_PC(9'd0), .FLUSH_CYCLES(0), .CNT_W(3)) dut_b (
      .clk(clk), .reset(rst), .Stall(stall), .PcSel(pcsel), .BrPC(br),
      .JalrSel(jsel), .JalrTarget(jt), .Cur_PC(pc_b), .PC_Valid(v_b),
      .Flush(f_b), .Misalign(m_b), .RedirectCnt(c_b)
   );

   // Reference model: remaining invalid slots, trap flag, PC and saturating count.
   int FL[2]   = '{2, 0};
   int CMAX[2] = '{65535, 7};
   int m_pc[2]   = '{0, 0};
   int m_bub[2]  = '{0, 0};
   bit m_trap[2] = '{0, 0};
   int m_cnt[2]  = '{0, 0};

   function automatic logic [27:0] exp_one(int k);
      bit val, fl;
      val = !rst && !m_trap[k] && (m_bub[k] == 0);
      fl  = val && (pcsel || jsel);
      return {9'(m_pc[k]), val, fl, m_trap[k], 16'(m_cnt[k])};
   endfunction

   function automatic logic [55:0] expv();
      return {exp_one(0), exp_one(1)};
   endfunction

   function automatic logic [55:0] act();
      return {pc_a, v_a, f_a, m_a, c_a, pc_b, v_b, f_b, m_b, 13'd0, c_b};
   endfunction

   task automatic tick();
      logic [31:0] t;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_pc[k] = 0; m_bub[k] = 0; m_trap[k] = 0; m_cnt[k] = 0;
         end else if (m_trap[k]) begin
         end else if (m_bub[k] > 0) begin
            m_bub[k]--;
         end else if (pcsel || jsel) begin
            t = jsel ? (jt & ~32'd1) : br;
            if ((t % 4 != 0) || (t >= 512)) m_trap[k] = 1;
            else begin
               m_pc[k]  = int'(t);
               m_bub[k] = FL[k];
               if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
            end
         end else if (!stall) begin
            m_pc[k] = (m_pc[k] + 4) % 512;
         end
      end
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic p, input logic [31:0] b,
                        input logic j, input logic [31:0] t);
      rst = r; stall = s; pcsel = p; br = b; jsel = j; jt = t;
      #1;
   endtask

   task automatic test_reset();
      drive(1, 0, 1, 32'h40, 0, 0);
      repeat (3) tick();
      if (act() !== expv()) begin failures++; $display("FAIL reset_hold act=%h exp=%h", act(), expv()); end
      checks++;
      drive(0, 0, 0, 0, 0, 0);
      if (pc_a !== 9'h000 || v_a !== 1'b1 || f_a !== 1'b0 || c_a !== 16'd0) begin
         failures++; $display("FAIL reset_release pc=%h v=%b f=%b cnt=%0d exp pc=000 v=1 f=0 cnt=0", pc_a, v_a, f_a, c_a);
      end
      checks++;
   endtask

   task automatic test_free_run();
      for (int i = 0; i < 5; i++) begin
         if (act() !== expv() || pc_a !== 9'(4 * i)) begin
            failures++; $display("FAIL free_run i=%0d act=%h exp=%h", i, act(), expv());
         end
         checks++;
         if (i < 4) tick();
      end
   endtask

   task automatic test_branch();
      drive(0, 0, 1, 32'h40, 0, 0);
      if (act() !== expv() || f_a !== 1'b1) begin failures++; $display("FAIL branch_flush act=%h exp=%h", act(), expv()); end
      checks++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         if (act() !== expv() || v_a !== 1'b0 || pc_a !== 9'h040) begin
            failures++; $display("FAIL branch_bubble i=%0d act=%h exp=%h", i, act(), expv());
         end
         checks++;
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         if (act() !== expv() || v_a !== 1'b1 || pc_a !== 9'(32'h40 + 4 * i) || c_a !== 16'd1) begin
            failures++; $display("FAIL branch_target i=%0d act=%h exp=%h", i, act(), expv());
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_jalr_priority();
      drive(0, 0, 1, 32'h80, 1, 32'hC5);
      if (act() !== expv()) begin failures++; $display("FAIL jalr_flush act=%h exp=%h", act(), expv()); end
      checks++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      if (act() !== expv() || pc_a !== 9'h0C4 || v_a !== 1'b1) begin
         failures++; $display("FAIL jalr_priority pc=%h act=%h exp=%h", pc_a, act(), expv());
      end
      checks++;
   endtask

   task automatic test_stall_redirect();
      drive(0, 1, 1, 32'h20, 0, 0);
      if (act() !== expv() || f_a !== 1'b1) begin failures++; $display("FAIL stall_redir_flush act=%h exp=%h", act(), expv()); end
      checks++;
      tick();
      drive(0, 0, 1, 32'h100, 0, 0);
      if (act() !== expv() || pc_a !== 9'h020 || f_a !== 1'b0) begin
         failures++; $display("FAIL bubble_ignore act=%h exp=%h", act(), expv());
      end
      checks++;
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      if (act() !== expv() || pc_a !== 9'h020 || v_a !== 1'b1) begin
         failures++; $display("FAIL stall_redir_target act=%h exp=%h", act(), expv());
      end
      checks++;
   endtask

   task automatic test_trap();
      for (int c = 0; c < 2; c++) begin
         if (c == 0) drive(0, 0, 0, 32'h40, 1, 32'h202);
         else        drive(0, 0, 1, 32'h400, 0, 0);
         if (act() !== expv() || f_a !== 1'b1) begin failures++; $display("FAIL trap_flush c=%0d act=%h exp=%h", c, act(), expv()); end
         checks++;
         tick();
         for (int i = 0; i < 4; i++) begin
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1), 32'h10, 0, 0);
            if (act() !== expv() || m_a !== 1'b1 || v_a !== 1'b0 || f_a !== 1'b0) begin
               failures++; $display("FAIL trap_hold c=%0d i=%0d act=%h exp=%h", c, i, act(), expv());
            end
            checks++;
            tick();
         end
         drive(1, 0, 0, 0, 0, 0);
         tick();
         drive(0, 0, 0, 0, 0, 0);
         if (act() !== expv() || pc_a !== 9'h000 || v_a !== 1'b1 || m_a !== 1'b0) begin
            failures++; $display("FAIL trap_reset c=%0d act=%h exp=%h", c, act(), expv());
         end
         checks++;
      end
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 32'h1F8, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         if (act() !== expv() || pc_a !== 9'(32'h1F8 + 4 * i)) begin
            failures++; $display("FAIL wrap i=%0d act=%h exp=%h", i, act(), expv());
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_saturate();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 32'($urandom_range(0, 127) * 4), 0, 0);
         if (act() !== expv()) begin failures++; $display("FAIL sat_redir i=%0d act=%h exp=%h", i, act(), expv()); end
         checks++;
         tick();
         drive(0, 1, 0, 0, 0, 0);
         if (act() !== expv() || v_b !== 1'b1 || pc_b !== pc_a) begin
            failures++; $display("FAIL zero_bubble i=%0d act=%h exp=%h", i, act(), expv());
         end
         checks++;
         repeat (2) tick();
      end
      if (c_b !== 3'd7) begin failures++; $display("FAIL sat_count act=%0d exp=7", c_b); end
      checks++;
   endtask

   task automatic test_random();
      logic [31:0] b, t;
      drive(1, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 500; i++) begin
         b = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127) * 4);
         t = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255) * 2);
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               b, $urandom_range(0, 7) == 0, t);
         if (act() !== expv()) begin failures++; $display("FAIL random i=%0d act=%h exp=%h", i, act(), expv()); end
         checks++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_branch();
      test_jalr_priority();
      test_stall_redirect();
      test_trap();
      test_wrap();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
